// File: rtl/peripheral_str_tx.sv
// String-RAM to UART transmitter: walks bytes from START_ADDR and sends each as 8N1 until NUL or LEN.
// Define STR_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module peripheral_str_tx #(
  parameter int CLK_DIV = 434,
  parameter int RAM_AW  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cs,
  input  logic              rd,
  input  logic              wr,
  input  logic [3:0]        addr,
  input  logic [7:0]        dat_in,
  output logic [7:0]        dat_out,
  output logic [RAM_AW-1:0] ram_addr,
  output logic              ram_rd,
  input  logic [7:0]        ram_data,
  output logic              txd,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_START, S_DATA, S_PARITY, S_STOP, S_FIN
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLK_DIV - 1);

  state_t            state_q, state_d;
  logic [RAM_AW-1:0] start_q, start_d;
  logic [RAM_AW-1:0] ptr_q, ptr_d;
  logic [7:0]        len_q, len_d;
  logic [8:0]        cnt_q, cnt_d;
  logic [15:0]       baud_q, baud_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic [7:0]        dout_q, dout_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              go_q, go_d;
`ifdef STR_TX_PARITY_EN
  logic              par_q, par_d;
`endif

  logic baud_end;
  logic len_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      start_q <= '0;
      ptr_q   <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      go_q    <= 1'b0;
`ifdef STR_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ptr_q   <= ptr_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      go_q    <= go_d;
`ifdef STR_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

  // Bus: a register access takes effect on any posedge with cs&wr (write) or cs&rd (read); no wait states.
  always_comb begin
    state_d  = state_q;
    start_d  = start_q;
    ptr_d    = ptr_q;
    len_d    = len_q;
    cnt_d    = cnt_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    dout_d   = dout_q;
    busy_d   = busy_q;
    done_d   = done_q;
    go_d     = go_q;
`ifdef STR_TX_PARITY_EN
    par_d    = par_q;
`endif
    baud_end = (baud_q == BAUD_LAST);
    len_hit  = (cnt_q == {1'b0, len_q});

    if (cs && rd) begin
      case (addr)
        4'h0:    dout_d = 8'(start_q);
        4'h2:    dout_d = {6'b0, done_q, busy_q};
        4'h4:    dout_d = len_q;
        default: dout_d = 8'h00;
      endcase
    end

    // GO is latched here and acted on one edge later, which is when busy rises.
    if (cs && wr && !busy_q && !go_q) begin
      case (addr)
        4'h0:    start_d = RAM_AW'(dat_in);
        4'h4:    len_d   = dat_in;
        4'h8:    go_d    = 1'b1;
        default: ;
      endcase
    end

    case (state_q)
      S_IDLE: begin
        if (go_q) begin
          go_d    = 1'b0;
          ptr_d   = start_q;
          cnt_d   = '0;
          done_d  = 1'b0;
          busy_d  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: state_d = len_hit ? S_FIN : S_WAIT;
      S_WAIT: begin
        if (ram_data == 8'h00) begin
          state_d = S_FIN;
        end else begin
          shift_d = ram_data;
          baud_d  = '0;
          bit_d   = '0;
`ifdef STR_TX_PARITY_EN
          par_d   = ^ram_data;
`endif
          state_d = S_START;
        end
      end
      S_START: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_DATA: begin
        if (baud_end) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
`ifdef STR_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
            bit_d   = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`ifdef STR_TX_PARITY_EN
      S_PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
`endif
      S_STOP: begin
        if (baud_end) begin
          baud_d  = '0;
          ptr_d   = ptr_q + RAM_AW'(1);
          cnt_d   = cnt_q + 9'd1;
          state_d = S_FETCH;
        end else begin
          baud_d = baud_q + 16'd1;
        end
      end
      S_FIN: begin
        busy_d  = 1'b0;
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    txd = 1'b1;
    case (state_q)
      S_START:  txd = 1'b0;
      S_DATA:   txd = shift_q[0];
`ifdef STR_TX_PARITY_EN
      S_PARITY: txd = par_q;
`endif
      default:  txd = 1'b1;
    endcase
  end

  assign ram_rd    = (state_q == S_FETCH) && !len_hit;
  assign ram_addr  = ptr_q;
  assign busy      = busy_q;
  assign dat_out   = dout_q;
  assign dbg_state = state_q;

endmodule
